multicycle_control: RTL
=======================

# multicycle_control

Multi-cycle sequencer for the 16-bit MIPS-based datapath. It drives the datapath's load strobes, mux selects, ALU operation, register-file write and memory handshake through FETCH / DECODE / EXEC / MEM / WB. Instructions are 16 bits: opcode[15:12], rs[11:8], rt[7:4], rd/imm[3:0] (imm is sign-extended), and jump target[11:0] combined with PC[15:12]. Memory is word-addressed, so PC increments by 1.

## Interface
Parameters: none.
- clk  in  1  rising-edge clock
- clr  in  1  synchronous active-high reset
- opcode  in  4  IR[15:12], valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_load  out  1  load IR
- mdr_load  out  1  load memory data register
- aluout_load  out  1  load ALUOut register
- pc_load  out  1  load PC
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump_combine
- alu_src_a  out  1  ALU A: 0 = PC, 1 = register A
- alu_src_b  out  2  ALU B: 00 = register B, 01 = constant 1, 10 = sign-extended imm
- alu_op  out  4  0 = ADD, 1 = SUB, 2 = AND, 3 = OR, 4 = XOR, 5 = SLT
- reg_write  out  1  register-file write enable
- reg_dst  out  1  write address: 0 = rd, 1 = rt
- mem_to_reg  out  1  write data: 0 = ALUOut, 1 = MDR
- retire  out  1  one-cycle pulse when an instruction completes
- halted  out  1  high while in HALT

## Operation
- Opcodes:
  - 0–5: R-type, alu_op = opcode
  - 6: ADDI (rt ← rs + imm)
  - 7: LW (rt ← M[rs + imm])
  - 8: SW (M[rs + imm] ← rt)
  - 9: BEQ (if rs == rt, PC ← PC + 1 + imm)
  - A: J
  - B–E: NOP
  - F: HALT
- Every output not listed for a state is 0.
- State register: 3 bits. Outputs are decoded combinationally from state, opcode, zero and mem_ready. Strobes take effect on the next rising clk.
- FETCH:
  - mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = ADD.
  - If mem_ready: ir_load = 1, pc_load = 1, pc_src = 00, go to DECODE. Otherwise stay.
- DECODE:
  - alu_src_a = 0, alu_src_b = 10, alu_op = ADD, aluout_load = 1 (branch target).
  - Next state by opcode: F → HALT. A → pc_load = 1, pc_src = 10, retire = 1, go to FETCH. B–E → retire = 1, go to FETCH. Otherwise → EXEC.
- EXEC:
  - R-type: alu_src_a = 1, alu_src_b = 00, alu_op = opcode, aluout_load = 1, go to WB.
  - ADDI/LW/SW: alu_src_a = 1, alu_src_b = 10, alu_op = ADD, aluout_load = 1. ADDI → WB; LW/SW → MEM.
  - BEQ: alu_src_a = 1, alu_src_b = 00, alu_op = SUB, retire = 1, go to FETCH. If zero: pc_load = 1, pc_src = 01.
- MEM: i_or_d = 1.
  - LW: mem_read = 1. If mem_ready: mdr_load = 1, go to WB.
  - SW: mem_write = 1. If mem_ready: retire = 1, go to FETCH.
  - Without mem_ready, stay with the request held.
- WB:
  - reg_write = 1, retire = 1, go to FETCH.
  - reg_dst = 1 for ADDI/LW; mem_to_reg = 1 for LW.
- HALT: halted = 1, all other outputs 0. Leave only via clr.
- mem_ready is ignored in any cycle where neither mem_read nor mem_write is asserted.

## Timing
- While clr = 1: all outputs 0. On the next edge the state becomes FETCH. The first cycle after clr falls shows mem_read = 1.
- clr in any state, including mid-handshake, aborts the access. The request drops in the cycle clr is high; no strobe fires.
- Cycles per instruction with mem_ready tied high:
  - J / NOP: 2
  - BEQ: 3
  - R-type / ADDI / SW: 4
  - LW: 5
  - HALT: enters HALT after 2 cycles
- Each cycle mem_ready is low in FETCH or MEM adds exactly one cycle.
- retire is high for exactly one cycle per completed instruction, and never for HALT.
- opcode and zero are sampled combinationally in the cycle they are used; the controller does not register them.

## Test plan
- Reset: hold clr for 3 cycles with mem_ready = 1 → all outputs 0 throughout. In the cycle after clr falls: mem_read = 1, i_or_d = 0, alu_src_b = 01.
- R-type XOR (opcode 4), mem_ready = 1 → states FETCH, DECODE, EXEC, WB. EXEC shows alu_op = 4, alu_src_a = 1. WB shows reg_write = 1, reg_dst = 0. retire pulses in WB. Next fetch on cycle 5.
- LW with mem_ready low for 2 cycles in MEM → mem_read and i_or_d held high for 3 cycles. mdr_load = 1 only in the ready cycle. WB shows mem_to_reg = 1, reg_dst = 1. Total 7 cycles.
- BEQ: with zero = 1, EXEC shows pc_load = 1, pc_src = 01. With zero = 0, pc_load = 0. Both cases return to FETCH after 3 cycles.
- J then HALT: J gives pc_load = 1, pc_src = 10 in DECODE. HALT gives halted = 1 and all other outputs 0 for 20 cycles. clr then restarts at FETCH.
- clr asserted during a FETCH wait (mem_ready = 0) → mem_read drops in the clr cycle; no ir_load or pc_load occurs; fetch restarts afterwards.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit multi-cycle MIPS datapath
module multicycle_control (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_load,
  output logic       mdr_load,
  output logic       aluout_load,
  output logic       pc_load,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_op,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       retire,
  output logic       halted
);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  state_t r_state, w_next;
  always_ff @(posedge clk)
    r_state <= clr ? S_FETCH : w_next;
  // clr forces every output low, which also drops any in-flight memory request
  always_comb begin
    w_next      = r_state;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    i_or_d      = 1'b0;
    ir_load     = 1'b0;
    mdr_load    = 1'b0;
    aluout_load = 1'b0;
    pc_load     = 1'b0;
    pc_src      = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 4'd0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    retire      = 1'b0;
    halted      = 1'b0;
    if (!clr)
      case (r_state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_load   = mem_ready;
          pc_load   = mem_ready;
          w_next    = mem_ready ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          alu_src_b   = 2'b10;
          aluout_load = 1'b1;
          pc_load     = opcode == 4'hA;
          pc_src      = opcode == 4'hA ? 2'b10 : 2'b00;
          retire      = opcode >= 4'hA && opcode != 4'hF;
          w_next      = opcode == 4'hF ? S_HALT : retire ? S_FETCH : S_EXEC;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          if (opcode <= 4'd5) begin
            alu_op      = opcode;
            aluout_load = 1'b1;
            w_next      = S_WB;
          end else if (opcode == 4'd9) begin
            alu_op  = 4'd1;
            retire  = 1'b1;
            pc_load = zero;
            pc_src  = zero ? 2'b01 : 2'b00;
            w_next  = S_FETCH;
          end else begin
            alu_src_b   = 2'b10;
            aluout_load = 1'b1;
            w_next      = opcode == 4'd6 ? S_WB : S_MEM;
          end
        end
        S_MEM: begin
          i_or_d    = 1'b1;
          mem_read  = opcode == 4'd7;
          mem_write = opcode != 4'd7;
          mdr_load  = mem_read && mem_ready;
          retire    = mem_write && mem_ready;
          w_next    = !mem_ready ? S_MEM : mem_read ? S_WB : S_FETCH;
        end
        S_WB: begin
          reg_write  = 1'b1;
          retire     = 1'b1;
          reg_dst    = opcode == 4'd6 || opcode == 4'd7;
          mem_to_reg = opcode == 4'd7;
          w_next     = S_FETCH;
        end
        S_HALT: halted = 1'b1;
        default: w_next = S_FETCH;
      endcase
  end
endmodule
